// File: rtl/uart_ram_loader_if.sv
// Byte-stream-in / RAM-write-out bundle of the UART RAM loader.
// The loader is the slave; the UART receiver and RAM are on the master side.
interface uart_ram_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, busy, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, busy, done, error
    );
endinterface

// File: rtl/uart_ram_loader.sv
// Parses SYNC/ADDR/LEN/DATA*N/CSUM frames into RAM writes; write, done and error are registered 1 cycle after the strobe.
// No backpressure: one byte per cycle is always accepted, bytes outside a frame other than SYNC are dropped.
module uart_ram_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter int         TO_W           = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_ram_loader_if.slave   bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_LEN  = 3'd2;
    localparam logic [2:0] GET_DATA = 3'd3;
    localparam logic [2:0] GET_CSUM = 3'd4;

    // Error is registered, so it is decided one count early to appear as the counter reaches TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]      state;
    logic [7:0]      ptr;
    logic [7:0]      csum;
    logic [8:0]      remaining;
    logic [TO_W-1:0] to_cnt;
    logic            wr_en_q;
    logic [7:0]      wr_addr_q;
    logic [7:0]      wr_data_q;
    logic            done_q;
    logic            error_q;
    logic            timeout;

    assign timeout = (state != IDLE) && !bus.rx_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            csum      <= 8'd0;
            remaining <= 9'd0;
            to_cnt    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;

            if (state == IDLE || bus.rx_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (timeout) begin
                error_q <= 1'b1;
                state   <= IDLE;
            end else if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == SYNC_BYTE)
                            state <= GET_ADDR;
                    end
                    GET_ADDR: begin
                        ptr   <= bus.rx_data;
                        csum  <= bus.rx_data;
                        state <= GET_LEN;
                    end
                    GET_LEN: begin
                        remaining <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                        csum      <= csum + bus.rx_data;
                        state     <= GET_DATA;
                    end
                    GET_DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr;
                        wr_data_q <= bus.rx_data;
                        ptr       <= ptr + 8'd1;
                        csum      <= csum + bus.rx_data;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1)
                            state <= GET_CSUM;
                    end
                    GET_CSUM: begin
                        if (bus.rx_data == csum)
                            done_q <= 1'b1;
                        else
                            error_q <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.done    = done_q;
    assign bus.error   = error_q;
    assign bus.busy    = (state != IDLE);

endmodule
